snake_game_ctrl: RTL and testbench
==================================

# snake_game_ctrl

Game sequencer that drives the `snake_game` datapath. It generates the variable-rate `game_tick` from the 100 MHz clock and arbitrates button presses into a legal `snake_direction`, with no reversal and at most one change per tick. It runs the IDLE/PLAY/PAUSE/OVER state machine from datapath events (`food_eaten`, `collision`) and keeps the score. It sits between the debounced button logic and `snake_game`.

## Interface
- `TICK_INIT`, default 10_000_000: initial tick period in clk cycles (10 Hz).
- `TICK_STEP`, default 500_000: period reduction per food eaten.
- `TICK_MIN`, default 2_000_000: floor on the tick period.
- `SCORE_W`, default 8: score width.
- `clk_100MHz`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`, in, 1 each: debounced one-cycle press pulses.
- `btn_start`, in, 1: debounced one-cycle start/pause pulse.
- `food_eaten`, in, 1: datapath pulse, valid in the cycle after `game_tick`.
- `collision`, in, 1: datapath pulse (wall or self), valid in the cycle after `game_tick`.
- `game_tick`, out, 1: one-cycle advance strobe to `snake_game`.
- `snake_direction`, out, 2: 00 right, 01 up, 10 left, 11 down.
- `snake_clear`, out, 1: one-cycle pulse that resets the snake body and food.
- `game_run`, out, 1: high in PLAY.
- `game_over`, out, 1: high in OVER.
- `score`, out, SCORE_W: foods eaten, saturating.

## Operation
- States: IDLE, INIT, PLAY, PAUSE, OVER. Reset → IDLE.
- IDLE: `btn_start` → INIT.
- INIT: lasts one cycle.
  - `snake_clear`=1.
  - score←0, period←TICK_INIT, counter←0.
  - committed and pending direction←00.
  - Next state PLAY.
- PLAY:
  - `collision` → OVER. Collision has priority over `btn_start` and `food_eaten` in the same cycle; that food is not scored.
  - Otherwise `btn_start` → PAUSE.
  - `food_eaten` (without collision): score+1, saturating at 2^SCORE_W−1; period←max(period−TICK_STEP, TICK_MIN).
- PAUSE:
  - Counter frozen (holds its value, not cleared); no ticks; button presses ignored.
  - `btn_start` → PLAY.
- OVER:
  - `game_over`=1; no ticks.
  - `btn_start` → INIT.
- Direction arbitration (PLAY only):
  - Several buttons in one cycle: priority up > down > left > right.
  - A candidate d is rejected if it is opposite the committed direction, i.e. d[0]==cur[0] and d[1]!=cur[1].
  - An accepted candidate overwrites pending; the last accepted press before the commit wins.
- Tick:
  - In PLAY the counter increments each cycle.
  - When the counter reaches period−1: counter←0, committed direction←pending.
  - `game_tick` pulses the following cycle, so `snake_direction` is stable ≥1 cycle before the tick.
- Period width: ceil(log2(TICK_INIT+1)) bits; subtraction must not underflow (compare before subtracting).

## Timing
- Reset values: `game_tick`=0, `snake_direction`=00, `snake_clear`=0, `game_run`=0, `game_over`=0, `score`=0, counter=0, period=TICK_INIT, state=IDLE.
- `btn_start` in IDLE at cycle n:
  - INIT at n+1 (`snake_clear` high at n+1).
  - PLAY at n+2.
  - First `game_tick` at n+2+period.
- Tick spacing is exactly `period` cycles in PLAY.
- A period change takes effect from the next counter wrap. If the new period ≤ the current count, the counter wraps on the next cycle.
- Leaving PLAY while a tick is pending (wrap occurred last cycle) still emits that `game_tick`; no further ticks after it.
- All outputs are registered. Asynchronous `reset` mid-game returns everything to reset values immediately.

## Structure
- Shared header `snake_defs.vh`:
  - Direction encodings DIR_RIGHT/UP/LEFT/DOWN.
  - State encodings.
  - The `is_opposite` rule as a macro or function.
- Sub-module `snake_tick_gen`: counter, period register, enable/freeze, wrap strobe.
- FSM, arbitration and score live in the top.

## Test plan
Use TICK_INIT=20, TICK_STEP=4, TICK_MIN=8.

- Reset, `btn_start` at cycle 5 → `snake_clear` at 6, `game_run` at 7, ticks at 27, 47, 67; `snake_direction`=00 throughout.
- Committed right, `btn_left` pulse → rejected, stays 00. Then `btn_up` and `btn_right` in the same cycle → 01 committed at the next wrap, visible one cycle before the tick.
- Five `food_eaten` pulses → score=5; tick spacing 16, 12, 8, 8, 8.
- `food_eaten` and `collision` in the same cycle → OVER, score unchanged, no further ticks. Then `btn_start` → `snake_clear`, score=0, spacing 20.
- Pause at count 7 for 100 cycles, then resume → next tick 13 cycles after resume; no ticks while paused.
- Assert `reset` between ticks in PLAY → all outputs at reset values within the same cycle; state IDLE.

Source files
------------

// File: rtl/snake_game_ctrl_pkg.sv
// Shared types for the snake game sequencer: direction and FSM state encodings
// plus the reversal rule used by the direction arbiter.
package snake_game_ctrl_pkg;

   typedef enum logic [1:0] {
      DIR_RIGHT = 2'b00,
      DIR_UP    = 2'b01,
      DIR_LEFT  = 2'b10,
      DIR_DOWN  = 2'b11
   } dir_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_PLAY,
      ST_PAUSE,
      ST_OVER
   } state_t;

   // Same axis (bit 0 equal) but opposite sense (bit 1 differs) is a reversal.
   function automatic logic is_opposite(input logic [1:0] d, input logic [1:0] cur);
      return (d[0] == cur[0]) && (d[1] != cur[1]);
   endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Variable-period tick timebase: free-running counter with freeze, period
// register that shrinks on request, a direction-commit strobe and a wrap strobe.
module snake_tick_gen #(
   parameter int unsigned TICK_INIT = 10_000_000,
   parameter int unsigned TICK_STEP = 500_000,
   parameter int unsigned TICK_MIN  = 2_000_000,
   parameter int unsigned PER_W     = $clog2(TICK_INIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   input  logic shrink,
   output logic commit,
   output logic wrap
);

   localparam logic [PER_W-1:0] P_INIT     = PER_W'(TICK_INIT);
   localparam logic [PER_W-1:0] P_STEP     = PER_W'(TICK_STEP);
   localparam logic [PER_W-1:0] P_MIN      = PER_W'(TICK_MIN);
   localparam logic [PER_W-1:0] P_ONE      = PER_W'(1);
   localparam logic [PER_W:0]   SHRINK_MIN = (PER_W + 1)'(TICK_MIN + TICK_STEP);

   logic [PER_W-1:0] count;
   logic [PER_W-1:0] period;
   logic [PER_W-1:0] count_inc;
   logic [PER_W-1:0] last;
   logic             armed;

   assign count_inc = count + P_ONE;
   assign last      = period - P_ONE;

   // >= rather than == so a period shrunk below the running count wraps at once.
   assign wrap   = en && (count >= last);
   // Commit one cycle ahead of the wrap so the direction settles before the
   // tick; armed keeps it to once per period, and if a shrink skips the early
   // slot the commit coincides with the wrap instead of being lost.
   assign commit = en && !armed && (count_inc >= last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= '0;
         period <= P_INIT;
         armed  <= 1'b0;
      end else if (clear) begin
         count  <= '0;
         period <= P_INIT;
         armed  <= 1'b0;
      end else begin
         if (en) begin
            count <= wrap ? '0 : count_inc;
            if (wrap)
               armed <= 1'b0;
            else if (commit)
               armed <= 1'b1;
         end
         if (shrink)
            period <= ({1'b0, period} >= SHRINK_MIN) ? (period - P_STEP) : P_MIN;
      end
   end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/INIT/PLAY/PAUSE/OVER control, direction
// arbitration with reversal lockout, score keeping and the game tick.
module snake_game_ctrl
   import snake_game_ctrl_pkg::*;
#(
   parameter int unsigned TICK_INIT = 10_000_000,
   parameter int unsigned TICK_STEP = 500_000,
   parameter int unsigned TICK_MIN  = 2_000_000,
   parameter int unsigned SCORE_W   = 8
) (
   input  logic               clk_100MHz,
   input  logic               reset,
   input  logic               btn_up,
   input  logic               btn_down,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic               btn_start,
   input  logic               food_eaten,
   input  logic               collision,
   output logic               game_tick,
   output logic [1:0]         snake_direction,
   output logic               snake_clear,
   output logic               game_run,
   output logic               game_over,
   output logic [SCORE_W-1:0] score
);

   localparam int unsigned PER_W = $clog2(TICK_INIT + 1);

   state_t state;
   state_t next_state;
   dir_t   cur_dir;
   dir_t   pend_dir;
   dir_t   pend_next;
   dir_t   cand;
   logic   cand_vld;
   logic   in_init;
   logic   in_play;
   logic   food_ok;
   logic   commit;
   logic   wrap;

   assign in_init = (state == ST_INIT);
   assign in_play = (state == ST_PLAY);
   // Collision wins over food in the same cycle: that food is never scored.
   assign food_ok = in_play && food_eaten && !collision;

   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:  if (btn_start) next_state = ST_INIT;
         ST_INIT:  next_state = ST_PLAY;
         ST_PLAY: begin
            if (collision)
               next_state = ST_OVER;
            else if (btn_start)
               next_state = ST_PAUSE;
         end
         ST_PAUSE: if (btn_start) next_state = ST_PLAY;
         ST_OVER:  if (btn_start) next_state = ST_INIT;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      cand     = DIR_RIGHT;
      cand_vld = 1'b0;
      if (btn_up) begin
         cand     = DIR_UP;
         cand_vld = 1'b1;
      end else if (btn_down) begin
         cand     = DIR_DOWN;
         cand_vld = 1'b1;
      end else if (btn_left) begin
         cand     = DIR_LEFT;
         cand_vld = 1'b1;
      end else if (btn_right) begin
         cand     = DIR_RIGHT;
         cand_vld = 1'b1;
      end
      pend_next = pend_dir;
      if (cand_vld && !is_opposite(cand, cur_dir))
         pend_next = cand;
   end

   snake_tick_gen #(
      .TICK_INIT (TICK_INIT),
      .TICK_STEP (TICK_STEP),
      .TICK_MIN  (TICK_MIN),
      .PER_W     (PER_W)
   ) u_tick_gen (
      .clk    (clk_100MHz),
      .rst    (reset),
      .clear  (in_init),
      .en     (in_play),
      .shrink (food_ok),
      .commit (commit),
      .wrap   (wrap)
   );

   // Status outputs are registered from next_state so they line up with state.
   always_ff @(posedge clk_100MHz or posedge reset) begin
      if (reset) begin
         game_tick   <= 1'b0;
         snake_clear <= 1'b0;
         game_run    <= 1'b0;
         game_over   <= 1'b0;
         score       <= '0;
         cur_dir     <= DIR_RIGHT;
         pend_dir    <= DIR_RIGHT;
      end else begin
         game_tick   <= wrap;
         snake_clear <= (next_state == ST_INIT);
         game_run    <= (next_state == ST_PLAY);
         game_over   <= (next_state == ST_OVER);
         case (state)
            ST_INIT: begin
               score    <= '0;
               cur_dir  <= DIR_RIGHT;
               pend_dir <= DIR_RIGHT;
            end
            ST_PLAY: begin
               pend_dir <= pend_next;
               if (commit)
                  cur_dir <= pend_next;
               if (food_ok && (score != '1))
                  score <= score + SCORE_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign snake_direction = cur_dir;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed self-checking bench for snake_game_ctrl with a short tick period
// (TICK_INIT=20, TICK_STEP=4, TICK_MIN=8).
module tb_snake_game_ctrl;

   logic       clk_100MHz = 1'b0;
   logic       reset      = 1'b1;
   logic       btn_up     = 1'b0;
   logic       btn_down   = 1'b0;
   logic       btn_left   = 1'b0;
   logic       btn_right  = 1'b0;
   logic       btn_start  = 1'b0;
   logic       food_eaten = 1'b0;
   logic       collision  = 1'b0;
   logic       game_tick;
   logic [1:0] snake_direction;
   logic       snake_clear;
   logic       game_run;
   logic       game_over;
   logic [7:0] score;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;
   int last_tick = 0;

   snake_game_ctrl #(
      .TICK_INIT (20),
      .TICK_STEP (4),
      .TICK_MIN  (8),
      .SCORE_W   (8)
   ) dut (
      .clk_100MHz      (clk_100MHz),
      .reset           (reset),
      .btn_up          (btn_up),
      .btn_down        (btn_down),
      .btn_left        (btn_left),
      .btn_right       (btn_right),
      .btn_start       (btn_start),
      .food_eaten      (food_eaten),
      .collision       (collision),
      .game_tick       (game_tick),
      .snake_direction (snake_direction),
      .snake_clear     (snake_clear),
      .game_run        (game_run),
      .game_over       (game_over),
      .score           (score)
   );

   always #5 clk_100MHz = ~clk_100MHz;
   always @(posedge clk_100MHz) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk_100MHz);
      #1;
   endtask

   task automatic wait_tick(output int at);
      at = -1;
      for (int i = 0; i < 300; i++) begin
         step();
         if (game_tick === 1'b1) begin
            at = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset();
      step(); step(); step();
      total++; if (game_tick !== 1'b0) begin bad++; $display("FAIL rst_tick got=%0d want=0", game_tick); end
      total++; if (snake_direction !== 2'b00) begin bad++; $display("FAIL rst_dir got=%0d want=0", snake_direction); end
      total++; if (snake_clear !== 1'b0) begin bad++; $display("FAIL rst_clear got=%0d want=0", snake_clear); end
      total++; if (game_run !== 1'b0) begin bad++; $display("FAIL rst_run got=%0d want=0", game_run); end
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL rst_over got=%0d want=0", game_over); end
      total++; if (score !== 8'd0) begin bad++; $display("FAIL rst_score got=%0d want=0", score); end
      reset = 1'b0;
      step(); step();
      total++; if (game_run !== 1'b0) begin bad++; $display("FAIL idle_run got=%0d want=0", game_run); end
   endtask

   task automatic test_start();
      int s, t1, t2, t3;
      s = cyc;
      btn_start = 1'b1; step(); btn_start = 1'b0;
      total++; if (snake_clear !== 1'b1) begin bad++; $display("FAIL start_clear got=%0d want=1", snake_clear); end
      total++; if (game_run !== 1'b0) begin bad++; $display("FAIL start_run_init got=%0d want=0", game_run); end
      step();
      total++; if (game_run !== 1'b1) begin bad++; $display("FAIL start_run got=%0d want=1", game_run); end
      total++; if (snake_clear !== 1'b0) begin bad++; $display("FAIL start_clear_off got=%0d want=0", snake_clear); end
      wait_tick(t1);
      total++; if (t1 !== s + 22) begin bad++; $display("FAIL first_tick got=%0d want=%0d", t1, s + 22); end
      wait_tick(t2);
      total++; if (t2 - t1 !== 20) begin bad++; $display("FAIL spacing1 got=%0d want=20", t2 - t1); end
      wait_tick(t3);
      total++; if (t3 - t2 !== 20) begin bad++; $display("FAIL spacing2 got=%0d want=20", t3 - t2); end
      total++; if (snake_direction !== 2'b00) begin bad++; $display("FAIL start_dir got=%0d want=0", snake_direction); end
      last_tick = t3;
   endtask

   task automatic test_direction();
      int t, tb;
      tb = last_tick;
      step(); btn_left = 1'b1; step(); btn_left = 1'b0;
      wait_tick(t);
      total++; if (t - tb !== 20) begin bad++; $display("FAIL dir_spacing got=%0d want=20", t - tb); end
      total++; if (snake_direction !== 2'b00) begin bad++; $display("FAIL reverse_rejected got=%0d want=0", snake_direction); end
      tb = t;
      step(); step();
      btn_up = 1'b1; btn_right = 1'b1; step(); btn_up = 1'b0; btn_right = 1'b0;
      while (cyc < tb + 18) step();
      total++; if (snake_direction !== 2'b00) begin bad++; $display("FAIL dir_early got=%0d want=0", snake_direction); end
      step();
      total++; if (snake_direction !== 2'b01) begin bad++; $display("FAIL dir_commit got=%0d want=1", snake_direction); end
      total++; if (game_tick !== 1'b0) begin bad++; $display("FAIL dir_pre_tick got=%0d want=0", game_tick); end
      step();
      total++; if (game_tick !== 1'b1) begin bad++; $display("FAIL dir_tick got=%0d want=1", game_tick); end
      total++; if (snake_direction !== 2'b01) begin bad++; $display("FAIL dir_hold got=%0d want=1", snake_direction); end
      last_tick = cyc;
   endtask

   task automatic test_food();
      int exp_sp [5] = '{16, 12, 8, 8, 8};
      int t, tb;
      tb = last_tick;
      for (int i = 0; i < 5; i++) begin
         step(); food_eaten = 1'b1; step(); food_eaten = 1'b0;
         wait_tick(t);
         total++; if (t - tb !== exp_sp[i]) begin bad++; $display("FAIL food_spacing%0d got=%0d want=%0d", i, t - tb, exp_sp[i]); end
         tb = t;
      end
      total++; if (score !== 8'd5) begin bad++; $display("FAIL food_score got=%0d want=5", score); end
      last_tick = tb;
   endtask

   task automatic test_collision();
      int n, s, t1, t2;
      step(); food_eaten = 1'b1; collision = 1'b1; step(); food_eaten = 1'b0; collision = 1'b0;
      total++; if (game_over !== 1'b1) begin bad++; $display("FAIL over_flag got=%0d want=1", game_over); end
      total++; if (game_run !== 1'b0) begin bad++; $display("FAIL over_run got=%0d want=0", game_run); end
      total++; if (score !== 8'd5) begin bad++; $display("FAIL over_score got=%0d want=5", score); end
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (game_tick === 1'b1) n++;
      end
      total++; if (n !== 0) begin bad++; $display("FAIL over_ticks got=%0d want=0", n); end
      s = cyc;
      btn_start = 1'b1; step(); btn_start = 1'b0;
      total++; if (snake_clear !== 1'b1) begin bad++; $display("FAIL restart_clear got=%0d want=1", snake_clear); end
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL restart_over got=%0d want=0", game_over); end
      step();
      total++; if (score !== 8'd0) begin bad++; $display("FAIL restart_score got=%0d want=0", score); end
      wait_tick(t1);
      total++; if (t1 !== s + 22) begin bad++; $display("FAIL restart_first got=%0d want=%0d", t1, s + 22); end
      wait_tick(t2);
      total++; if (t2 - t1 !== 20) begin bad++; $display("FAIL restart_spacing got=%0d want=20", t2 - t1); end
      last_tick = t2;
   endtask

   task automatic test_pause();
      int n, r, t;
      while (cyc < last_tick + 6) step();
      btn_start = 1'b1; step(); btn_start = 1'b0;
      total++; if (game_run !== 1'b0) begin bad++; $display("FAIL pause_run got=%0d want=0", game_run); end
      n = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (game_tick === 1'b1) n++;
      end
      total++; if (n !== 0) begin bad++; $display("FAIL pause_ticks got=%0d want=0", n); end
      r = cyc;
      btn_start = 1'b1; step(); btn_start = 1'b0;
      total++; if (game_run !== 1'b1) begin bad++; $display("FAIL resume_run got=%0d want=1", game_run); end
      wait_tick(t);
      total++; if (t !== r + 14) begin bad++; $display("FAIL resume_tick got=%0d want=%0d", t, r + 14); end
      last_tick = t;
   endtask

   task automatic test_reset_mid();
      int t;
      step(); food_eaten = 1'b1; btn_down = 1'b1; step(); food_eaten = 1'b0; btn_down = 1'b0;
      total++; if (score !== 8'd1) begin bad++; $display("FAIL mid_score got=%0d want=1", score); end
      wait_tick(t);
      total++; if (t - last_tick !== 16) begin bad++; $display("FAIL mid_spacing got=%0d want=16", t - last_tick); end
      total++; if (snake_direction !== 2'b11) begin bad++; $display("FAIL mid_dir got=%0d want=3", snake_direction); end
      step(); step(); step();
      #2 reset = 1'b1;
      #1;
      total++; if (game_tick !== 1'b0) begin bad++; $display("FAIL areset_tick got=%0d want=0", game_tick); end
      total++; if (snake_direction !== 2'b00) begin bad++; $display("FAIL areset_dir got=%0d want=0", snake_direction); end
      total++; if (snake_clear !== 1'b0) begin bad++; $display("FAIL areset_clear got=%0d want=0", snake_clear); end
      total++; if (game_run !== 1'b0) begin bad++; $display("FAIL areset_run got=%0d want=0", game_run); end
      total++; if (game_over !== 1'b0) begin bad++; $display("FAIL areset_over got=%0d want=0", game_over); end
      total++; if (score !== 8'd0) begin bad++; $display("FAIL areset_score got=%0d want=0", score); end
      step(); step();
      reset = 1'b0;
      step(); step(); step();
      total++; if (game_run !== 1'b0 || snake_clear !== 1'b0) begin bad++; $display("FAIL areset_idle got=%0d want=0", {game_run, snake_clear}); end
      last_tick = cyc;
      btn_start = 1'b1; step(); btn_start = 1'b0;
      total++; if (snake_clear !== 1'b1) begin bad++; $display("FAIL areset_start got=%0d want=1", snake_clear); end
      wait_tick(t);
      total++; if (t !== last_tick + 22) begin bad++; $display("FAIL areset_first got=%0d want=%0d", t, last_tick + 22); end
      last_tick = t;
   endtask

   task automatic test_saturate();
      int t, tb, sp;
      tb = last_tick;
      sp = 0;
      for (int i = 0; i < 260; i++) begin
         step(); food_eaten = 1'b1; step(); food_eaten = 1'b0;
         wait_tick(t);
         sp = t - tb;
         tb = t;
      end
      total++; if (score !== 8'd255) begin bad++; $display("FAIL sat_score got=%0d want=255", score); end
      total++; if (sp !== 8) begin bad++; $display("FAIL sat_spacing got=%0d want=8", sp); end
      total++; if (game_run !== 1'b1) begin bad++; $display("FAIL sat_run got=%0d want=1", game_run); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_direction();
      test_food();
      test_collision();
      test_pause();
      test_reset_mid();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
